// File: rtl/boot_loader_pkg.sv
// Shared types and defaults for the IMEM boot loader.
//   bl_state_e : loader/supervisor state encoding
//   bl_flags_t : registered status outputs that depend only on the state
//   flags_of() : status flags for a given state
package boot_loader_pkg;

  localparam logic [7:0]  FILL_WORD_DEF  = 8'h00;  // NOP
  localparam int unsigned RST_HOLD_DEF   = 4;
  localparam int unsigned SETTLE_CYC_DEF = 20;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_LOAD    = 3'd2,
    S_HOLD    = 3'd3,
    S_RUN     = 3'd4,
    S_SETTLE  = 3'd5,
    S_DONE    = 3'd6,
    S_TIMEOUT = 3'd7
  } bl_state_e;

  typedef struct packed {
    logic busy;
    logic done;
    logic timed_out;
    logic cpu_run;   // drives cpu_rst_n
    logic ld_ready;
  } bl_flags_t;

  // Flags to register alongside a state change so they track the new state.
  function automatic bl_flags_t flags_of(input bl_state_e s);
    bl_flags_t f;
    f = '0;
    case (s)
      S_CLEAR, S_HOLD: f.busy = 1'b1;
      S_LOAD:          begin f.busy = 1'b1; f.ld_ready = 1'b1; end
      S_RUN, S_SETTLE: begin f.busy = 1'b1; f.cpu_run  = 1'b1; end
      S_DONE:          begin f.done = 1'b1; f.cpu_run  = 1'b1; end
      S_TIMEOUT:       f.timed_out = 1'b1;
      default:         f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/bl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority).
//   clk, rst_n : clock, async active-low reset
//   i_clr      : zero the count
//   i_inc      : count up by one, holding at all-ones
//   o_cnt      : current count
module bl_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/imem_boot_loader.sv
// Program loader and run supervisor for the 8-bit processor.
// Streams an image into IMEM while holding the core in reset, releases it,
// then watches the fetch PC for a halt address with an optional timeout.
// Optional build macro IMEM_BOOT_CLEAR_EN: fill all of IMEM with FILL_WORD
// before loading; without it start goes straight to LOAD.
// Ports:
//   clk, rst_n                    : clock, async active-low reset
//   start, abort                  : begin sequence / return to IDLE
//   halt_addr, timeout_cyc        : halt PC, run cycle limit (0 = none)
//   ld_valid/ready/addr/data/last : image beat stream
//   mem_we/addr/wdata             : IMEM write port (registered)
//   cpu_rst_n, cpu_pc             : core reset out, core fetch PC in
//   busy, done, timed_out         : status levels
//   run_cycles                    : saturating count of RUN cycles
module imem_boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
`ifdef IMEM_BOOT_CLEAR_EN
  parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(FILL_WORD_DEF),
`endif
  parameter int unsigned RST_HOLD   = RST_HOLD_DEF,
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] halt_addr,
  input  logic [CNT_W-1:0]  timeout_cyc,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst_n,
  input  logic [ADDR_W-1:0] cpu_pc,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic [CNT_W-1:0]  run_cycles
);

  bl_state_e         r_state;
  bl_flags_t         r_flags;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
`ifdef IMEM_BOOT_CLEAR_EN
  logic [ADDR_W-1:0] r_clr_addr;
`endif

  logic [CNT_W-1:0]  w_seq_cnt;
  logic [CNT_W-1:0]  w_run_cnt;
  logic              w_idle_like;
  logic              w_accept;
  logic              w_halt_hit;
  logic              w_timeout_hit;
  logic              w_hold_end;
  logic              w_settle_end;
  logic              w_seq_clr;
  logic              w_run_clr;
  logic              w_run_inc;

  assign w_idle_like   = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_TIMEOUT);
  assign w_accept      = ld_valid && r_flags.ld_ready;
  assign w_halt_hit    = (cpu_pc == halt_addr);
  assign w_timeout_hit = (timeout_cyc != '0) && (w_run_cnt == timeout_cyc - CNT_W'(1));
  assign w_hold_end    = (w_seq_cnt == CNT_W'(RST_HOLD - 1));
  assign w_settle_end  = (w_seq_cnt == CNT_W'(SETTLE_CYC - 1));

  // Sequencing counter restarts at 0 on every entry to HOLD or SETTLE.
  assign w_seq_clr = !((r_state == S_HOLD) || (r_state == S_SETTLE));
  assign w_run_clr = abort || (w_idle_like && start);
  assign w_run_inc = (r_state == S_RUN);

  bl_sat_counter #(.W(CNT_W)) u_seq_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_seq_clr),
    .i_inc (1'b1),
    .o_cnt (w_seq_cnt)
  );

  bl_sat_counter #(.W(CNT_W)) u_run_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_run_clr),
    .i_inc (w_run_inc),
    .o_cnt (w_run_cnt)
  );

  // Loader/supervisor FSM; status flags are registered with each state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_flags     <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
`ifdef IMEM_BOOT_CLEAR_EN
      r_clr_addr  <= '0;
`endif
    end else begin
      r_mem_we <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
        r_flags <= flags_of(S_IDLE);
      end else begin
        case (r_state)
          S_IDLE, S_DONE, S_TIMEOUT: begin
            if (start) begin
`ifdef IMEM_BOOT_CLEAR_EN
              r_state    <= S_CLEAR;
              r_flags    <= flags_of(S_CLEAR);
              r_clr_addr <= '0;
`else
              r_state <= S_LOAD;
              r_flags <= flags_of(S_LOAD);
`endif
            end
          end
`ifdef IMEM_BOOT_CLEAR_EN
          S_CLEAR: begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_clr_addr;
            r_mem_wdata <= FILL_WORD;
            r_clr_addr  <= r_clr_addr + ADDR_W'(1);
            if (r_clr_addr == {ADDR_W{1'b1}}) begin
              r_state <= S_LOAD;
              r_flags <= flags_of(S_LOAD);
            end
          end
`endif
          S_LOAD: begin
            if (w_accept) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= ld_addr;
              r_mem_wdata <= ld_data;
              if (ld_last) begin
                r_state <= S_HOLD;
                r_flags <= flags_of(S_HOLD);
              end
            end
          end
          S_HOLD: begin
            if (w_hold_end) begin
              r_state <= S_RUN;
              r_flags <= flags_of(S_RUN);
            end
          end
          S_RUN: begin
            // Halt has priority over a coincident timeout.
            if (w_halt_hit) begin
              r_state <= S_SETTLE;
              r_flags <= flags_of(S_SETTLE);
            end else if (w_timeout_hit) begin
              r_state <= S_TIMEOUT;
              r_flags <= flags_of(S_TIMEOUT);
            end
          end
          S_SETTLE: begin
            if (w_settle_end) begin
              r_state <= S_DONE;
              r_flags <= flags_of(S_DONE);
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_flags <= flags_of(S_IDLE);
          end
        endcase
      end
    end
  end

  assign ld_ready   = r_flags.ld_ready;
  assign busy       = r_flags.busy;
  assign done       = r_flags.done;
  assign timed_out  = r_flags.timed_out;
  assign cpu_rst_n  = r_flags.cpu_run;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign run_cycles = w_run_cnt;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed/randomized bench for imem_boot_loader.
// IMEM is modelled as an array written through the DUT write port; the
// expected image, write counts and cycle timings come from a reference
// array and plain cycle arithmetic kept here.
`timescale 1ns/1ps

`define CHK(TAG, OBS, EXP) \
  begin \
    n_tests++; \
    assert ((OBS) === (EXP)) else begin \
      n_fail++; \
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", TAG, (OBS), (EXP)); \
    end \
  end

module tb_imem_boot_loader;

  localparam int RST_HOLD = 4;
  localparam int SETTLE   = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [7:0]  halt_addr;
  logic [15:0] timeout_cyc;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_addr;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_rst_n;
  logic [7:0]  cpu_pc;
  logic        busy;
  logic        done;
  logic        timed_out;
  logic [15:0] run_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] imem    [256];
  logic [7:0] ref_mem [256];
  logic       seed_mem;
  int         wr_cnt;
  int         wr_base;
  int         exp_writes;
  logic [7:0] img_a [$];
  logic [7:0] img_d [$];

  always #5 clk = ~clk;

  imem_boot_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .halt_addr   (halt_addr),
    .timeout_cyc (timeout_cyc),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .cpu_rst_n   (cpu_rst_n),
    .cpu_pc      (cpu_pc),
    .busy        (busy),
    .done        (done),
    .timed_out   (timed_out),
    .run_cycles  (run_cycles)
  );

  // IMEM behind the write port
  always @(posedge clk) begin
    if (seed_mem) begin
      for (int i = 0; i < 256; i++) imem[i] <= ref_mem[i];
      wr_cnt <= 0;
    end else if (mem_we === 1'b1) begin
      imem[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] nonhalt();
    logic [7:0] v;
    do v = 8'($urandom); while (v == halt_addr);
    return v;
  endfunction

  task automatic gen_image(input int n);
    img_a.delete();
    img_d.delete();
    for (int i = 0; i < n; i++) begin
      img_a.push_back(8'($urandom));
      img_d.push_back(8'($urandom));
    end
  endtask

  task automatic do_start();
    cpu_pc  = 8'h00;
    wr_base = wr_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    `CHK("start_busy", busy, 1'b1)
    `CHK("start_flags_clear", {done, timed_out, cpu_rst_n}, 3'b000)
`ifdef IMEM_BOOT_CLEAR_EN
    begin
      int cyc;
      cyc = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
      exp_writes = 256;
      while (ld_ready !== 1'b1 && cyc < 400) begin
        tick();
        cyc++;
      end
      `CHK("clear_cycles", cyc, 256)
    end
`else
    exp_writes = 0;
    `CHK("start_ready", ld_ready, 1'b1)
`endif
  endtask

  // Stream the image, then cover HOLD up to the RUN entry edge.
  task automatic load_image();
    int bad;
    for (int i = 0; i < img_a.size(); i++) begin
      if ($urandom_range(0, 2) == 0) begin
        ld_valid = 1'b0;
        tick();
        `CHK("gap_no_write", mem_we, 1'b0)
      end
      `CHK("ready_in_load", ld_ready, 1'b1)
      ld_valid = 1'b1;
      ld_addr  = img_a[i];
      ld_data  = img_d[i];
      ld_last  = (i == img_a.size() - 1);
      tick();
      `CHK("write_latency1", {mem_we, mem_addr, mem_wdata}, {1'b1, img_a[i], img_d[i]})
      ref_mem[img_a[i]] = img_d[i];
      exp_writes++;
    end
    ld_addr = 8'($urandom);
    ld_data = 8'($urandom);
    ld_last = 1'b0;
    for (int j = 1; j <= 2; j++) begin
      tick();
      `CHK("no_write_in_hold", {mem_we, ld_ready, cpu_rst_n}, 3'b000)
    end
    ld_valid = 1'b0;
    for (int h = 3; h <= RST_HOLD; h++) begin
      tick();
      `CHK("hold_release", cpu_rst_n, (h == RST_HOLD))
    end
    bad = 0;
    for (int a = 0; a < 256; a++) if (imem[a] !== ref_mem[a]) bad++;
    `CHK("imem_contents", bad, 0)
    `CHK("write_count", wr_cnt - wr_base, exp_writes)
  endtask

  task automatic run_to_halt(input int k, input logic glitch);
    `CHK("run_entry", {busy, cpu_rst_n, run_cycles}, {1'b1, 1'b1, 16'd0})
    for (int i = 0; i < k; i++) begin
      cpu_pc = nonhalt();
      start  = glitch && (i == 1);
      tick();
      start  = 1'b0;
    end
    `CHK("still_running", {busy, cpu_rst_n, done, timed_out}, 4'b1100)
    cpu_pc = halt_addr;
    tick();
    `CHK("halt_run_cycles", run_cycles, 16'(k + 1))
    for (int s = 1; s <= SETTLE; s++) begin
      tick();
      `CHK("settle_done", done, (s == SETTLE))
    end
    `CHK("done_state", {busy, cpu_rst_n, timed_out, run_cycles}, {1'b0, 1'b1, 1'b0, 16'(k + 1)})
  endtask

  task automatic run_to_timeout(input int t);
    `CHK("run_entry", {busy, cpu_rst_n, run_cycles}, {1'b1, 1'b1, 16'd0})
    for (int i = 1; i <= t; i++) begin
      cpu_pc = nonhalt();
      tick();
      `CHK("timeout_flag", timed_out, (i == t))
    end
    `CHK("timeout_state", {busy, cpu_rst_n, done, run_cycles}, {1'b0, 1'b0, 1'b0, 16'(t)})
  endtask

  initial begin
    rst_n = 1'b0;
    seed_mem = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    ld_valid = 1'b0;
    ld_addr = 8'h00;
    ld_data = 8'h00;
    ld_last = 1'b0;
    halt_addr = 8'hFF;
    timeout_cyc = 16'd0;
    cpu_pc = 8'h00;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);

    // reset values
    repeat (3) tick();
    `CHK("reset_values", {cpu_rst_n, mem_we, mem_addr, mem_wdata, ld_ready, busy, done, timed_out, run_cycles}, 38'd0)
    seed_mem = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    `CHK("idle_after_reset", {busy, ld_ready, cpu_rst_n}, 3'b000)

    // image at 00/01/FF, core spins at FF; a start pulse mid-run is ignored
    img_a.delete();
    img_d.delete();
    img_a.push_back(8'h00); img_d.push_back(8'($urandom));
    img_a.push_back(8'h01); img_d.push_back(8'($urandom));
    img_a.push_back(8'hFF); img_d.push_back(8'($urandom));
    do_start();
    load_image();
`ifdef IMEM_BOOT_CLEAR_EN
    `CHK("cleared_word_02", imem[2], 8'h00)
`endif
    run_to_halt($urandom_range(5, 40), 1'b1);

    // timeout after 50 RUN cycles, started from DONE
    timeout_cyc = 16'd50;
    gen_image(3);
    do_start();
    load_image();
    run_to_timeout(50);

    // halt and timeout on the same cycle: halt wins
    timeout_cyc = 16'($urandom_range(8, 30));
    gen_image(2);
    do_start();
    load_image();
    run_to_halt(int'(timeout_cyc) - 1, 1'b0);

    // abort in RUN, abort beats start, then a clean restart
    timeout_cyc = 16'd0;
    gen_image(4);
    do_start();
    load_image();
    for (int i = 0; i < 10; i++) begin
      cpu_pc = nonhalt();
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    `CHK("abort_idle", {busy, cpu_rst_n, done, timed_out, ld_ready, mem_we}, 6'b000000)
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    `CHK("abort_beats_start", {busy, ld_ready, cpu_rst_n}, 3'b000)
    gen_image(5);
    do_start();
    load_image();
    run_to_halt($urandom_range(3, 25), 1'b0);

    // async reset during LOAD, then reload
    gen_image(3);
    do_start();
    ld_valid = 1'b1;
    ld_addr  = 8'($urandom);
    ld_data  = 8'($urandom);
    ld_last  = 1'b0;
    tick();
    `CHK("pre_reset_write", mem_we, 1'b1)
    #2 rst_n = 1'b0;
    #1;
    `CHK("async_reset", {cpu_rst_n, mem_we, mem_addr, mem_wdata, ld_ready, busy, done, timed_out, run_cycles}, 38'd0)
    ld_valid = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    `CHK("idle_after_midreset", {busy, ld_ready, mem_we}, 3'b000)
    gen_image(4);
    do_start();
    load_image();
    run_to_halt($urandom_range(3, 25), 1'b0);

    // randomized halt address, timeout and outcome
    for (int r = 0; r < 3; r++) begin
      halt_addr   = 8'($urandom);
      timeout_cyc = 16'($urandom_range(15, 60));
      gen_image($urandom_range(1, 6));
      do_start();
      load_image();
      if ($urandom_range(0, 1) == 1) run_to_halt($urandom_range(2, int'(timeout_cyc) - 1), 1'b0);
      else run_to_timeout(int'(timeout_cyc));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`undef CHK
